rdata3_fetch_ctrl: RTL and testbench
====================================

RDATA3_FETCH_CTRL -- requirements
Module: rdata3_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, AXI byte-address width.
REQ-002 SHALL have parameter DATA_W, default 16, read-data width, equal to the rdata3 prefetch FIFO write width.
REQ-003 SHALL have parameter BURST_LEN, default 16, maximum beats per burst, range 1..256.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 frame_start  input  1  one-cycle pulse that starts a frame fetch.
REQ-007 base_addr  input  ADDR_W  frame byte start address, sampled on accepted frame_start.
REQ-008 frame_beats  input  24  total beats per frame, sampled on accepted frame_start.
REQ-009 busy  output  1  high from accepted frame_start until frame done.
REQ-010 frame_done  output  1  one-cycle pulse after the last beat is written to the FIFO.
REQ-011 araddr / arlen / arvalid  output  ADDR_W / 8 / 1  AXI read-address channel.
REQ-012 arready  input  1  AXI read-address ready.
REQ-013 rdata / rvalid / rlast / rresp  input  DATA_W / 1 / 1 / 2  AXI read-data channel.
REQ-014 rready  output  1  AXI read-data ready.
REQ-015 fifo_wr_en / fifo_wr_data  output  1 / DATA_W  write port into the prefetch FIFO.
REQ-016 fifo_wr_vld  input  1  FIFO can accept a write this cycle (not full).

Function
REQ-017 State machine SHALL use states IDLE, ADDR, DATA, DONE.
REQ-018 IDLE: frame_start with frame_beats!=0 SHALL latch the inputs, set busy and go to ADDR; frame_start with frame_beats==0 SHALL pulse frame_done next cycle without any AR.
REQ-019 frame_start outside IDLE SHALL be ignored.
REQ-020 ADDR: arvalid=1; arlen=min(remaining,BURST_LEN)-1; araddr/arlen SHALL hold stable until arvalid&arready, then go to DATA.
REQ-021 Exactly one burst SHALL be outstanding at any time.
REQ-022 DATA: rready=fifo_wr_vld (combinational); fifo_wr_en=rvalid&rready; fifo_wr_data=rdata, zero added latency.
REQ-023 Each accepted beat SHALL decrement remaining by 1.
REQ-024 On an accepted beat with rlast=1: if remaining reaches 0 go to DONE, else advance araddr by BURST_LEN*DATA_W/8 bytes and go to ADDR.
REQ-025 Final partial burst SHALL use arlen=remaining-1.
REQ-026 DONE: pulse frame_done one cycle, clear busy, return to IDLE; back-to-back frame_start is accepted the cycle after DONE.
REQ-027 Address SHALL wrap modulo 2^ADDR_W.
REQ-028 Bursts SHALL NOT cross 4 KB; base_addr alignment to BURST_LEN*DATA_W/8 is a configuration precondition, not checked.
REQ-029 rvalid outside DATA SHALL be ignored (rready=0); rlast arriving early or late relative to arlen SHALL NOT be corrected; remaining alone governs frame end.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, busy=0, frame_done=0, arvalid=0, rready=0, fifo_wr_en=0, araddr=0, arlen=0, remaining=0.
REQ-031 Reset mid-burst SHALL abandon the frame with no further FIFO writes; outstanding AXI beats are the interconnect reset's responsibility.

Configuration
REQ-032 With RDATA3_FETCH_ERR_EN defined: output rd_err (1 bit) SHALL set sticky on any accepted beat with rresp!=0, clear on accepted frame_start or reset; data still written.
REQ-033 Without RDATA3_FETCH_ERR_EN: rd_err port and logic SHALL be absent; rresp ignored.

Verification
REQ-034 base_addr=0x1000, frame_beats=40, BURST_LEN=16, arready/rvalid always 1 -> ARs 0x1000/15, 0x1020/15, 0x1040/7; 40 FIFO writes; one frame_done.
REQ-035 fifo_wr_vld low for 5 cycles mid-burst -> rready low those 5 cycles, no writes, no data loss, order preserved.
REQ-036 arready held low 10 cycles -> araddr/arlen/arvalid stable throughout, no second AR.
REQ-037 frame_start with frame_beats=0 -> no AR, frame_done pulse next cycle; frame_start while busy -> ignored.
REQ-038 rst_n low during 2nd burst -> all outputs at reset values same cycle; new frame after release fetches from new base_addr.
REQ-039 With RDATA3_FETCH_ERR_EN, one beat rresp=2'b10 -> rd_err=1 until next frame_start; without the macro, identical data flow and no rd_err.

Source files
------------

// File: rtl/rdata3_fetch_ctrl_if.sv
// AXI read-address/read-data channels plus the prefetch FIFO write port of the
// rdata3 frame fetch controller, with master (controller) and slave (fabric/FIFO) views.
interface rdata3_fetch_ctrl_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rlast;
  logic [1:0]        rresp;
  logic              rready;

  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              fifo_wr_vld;

  modport master (
    output araddr, arlen, arvalid, rready, fifo_wr_en, fifo_wr_data,
    input  arready, rdata, rvalid, rlast, rresp, fifo_wr_vld
  );

  modport slave (
    input  araddr, arlen, arvalid, rready, fifo_wr_en, fifo_wr_data,
    output arready, rdata, rvalid, rlast, rresp, fifo_wr_vld
  );
endinterface

// File: rtl/rdata3_fetch_ctrl.sv
// Frame fetch controller: splits a frame into AXI read bursts (one outstanding) and
// streams beats into the prefetch FIFO. Define RDATA3_FETCH_ERR_EN to add the sticky rd_err output.
module rdata3_fetch_ctrl #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [23:0]         frame_beats,
  output logic                busy,
  output logic                frame_done,
`ifdef RDATA3_FETCH_ERR_EN
  output logic                rd_err,
`endif
  rdata3_fetch_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [23:0]       BURST_LEN_W = 24'(BURST_LEN);
  localparam logic [7:0]        ARLEN_MAX   = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] araddr_reg;
  logic [7:0]        arlen_reg;
  logic [23:0]       remaining_reg;
  logic [23:0]       remaining_dec;
  logic              start_acc;
  logic              beat_acc;
  logic              last_beat;
  logic              burst_end;
  logic              arvalid_c;
  logic              rready_c;

  // arlen for the next burst: full bursts until the tail, then the remainder.
  function automatic logic [7:0] burst_len_m1(input logic [23:0] beats);
    return (beats >= BURST_LEN_W) ? ARLEN_MAX : 8'(beats - 24'd1);
  endfunction

  assign start_acc     = (state_reg == IDLE) && frame_start;
  assign beat_acc      = (state_reg == DATA) && bus.fifo_wr_vld && bus.rvalid;
  assign remaining_dec = remaining_reg - 24'd1;
  // Frame end follows the beat count only; rlast merely closes a burst early or on time.
  assign last_beat     = beat_acc && (remaining_reg == 24'd1);
  assign burst_end     = beat_acc && bus.rlast && !last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    arvalid_c  = 1'b0;
    rready_c   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          state_next = (frame_beats != 24'd0) ? ADDR : DONE;
        end
      end
      ADDR: begin
        busy      = 1'b1;
        arvalid_c = 1'b1;
        if (bus.arready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        busy     = 1'b1;
        rready_c = bus.fifo_wr_vld;
        if (last_beat) begin
          state_next = DONE;
        end else if (burst_end) begin
          state_next = ADDR;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address and length registers only move in IDLE (load) and on a burst boundary,
  // so they stay stable for the whole time arvalid is up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_reg    <= '0;
      arlen_reg     <= '0;
      remaining_reg <= '0;
    end else if (start_acc) begin
      remaining_reg <= frame_beats;
      if (frame_beats != 24'd0) begin
        araddr_reg <= base_addr;
        arlen_reg  <= burst_len_m1(frame_beats);
      end
    end else if (beat_acc) begin
      remaining_reg <= remaining_dec;
      if (burst_end) begin
        araddr_reg <= araddr_reg + BURST_BYTES;
        arlen_reg  <= burst_len_m1(remaining_dec);
      end
    end
  end

`ifdef RDATA3_FETCH_ERR_EN
  logic rd_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_err_reg <= 1'b0;
    end else if (start_acc) begin
      rd_err_reg <= 1'b0;
    end else if (beat_acc && (bus.rresp != 2'b00)) begin
      rd_err_reg <= 1'b1;
    end
  end

  assign rd_err = rd_err_reg;
`else
  logic rresp_unused;
  assign rresp_unused = ^bus.rresp;
`endif

  assign bus.araddr       = araddr_reg;
  assign bus.arlen        = arlen_reg;
  assign bus.arvalid      = arvalid_c;
  assign bus.rready       = rready_c;
  assign bus.fifo_wr_en   = beat_acc;
  assign bus.fifo_wr_data = bus.rdata;

endmodule

// File: tb/tb_rdata3_fetch_ctrl.sv
// Randomized bench for rdata3_fetch_ctrl: an AXI slave/FIFO model plus a frame-level
// reference model, checked every cycle, with directed pins for the fixed scenarios.
module tb_rdata3_fetch_ctrl;
  localparam int AW = 28;
  localparam int DW = 16;
  localparam int BL = 16;
  localparam int BB = BL * DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [23:0]   frame_beats = '0;
  logic          busy;
  logic          frame_done;
`ifdef RDATA3_FETCH_ERR_EN
  logic          rd_err;
  bit            m_err = 1'b0;
`endif

  rdata3_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  rdata3_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .base_addr   (base_addr),
    .frame_beats (frame_beats),
    .busy        (busy),
    .frame_done  (frame_done),
`ifdef RDATA3_FETCH_ERR_EN
    .rd_err      (rd_err),
`endif
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  // 0 = random, 1 = always high, 2 = forced low
  int ar_mode = 1;
  int rv_mode = 1;
  int wv_mode = 1;
  int err_mode = 0;
  int dut_wr_count = 0;
  int done_count = 0;

  logic [AW-1:0] ar_addr_log[$];
  logic [7:0]    ar_len_log[$];
  logic [AW-1:0] exp_ar_addr[$];
  logic [7:0]    exp_ar_len[$];
  logic [DW-1:0] exp_data[$];
  bit            m_active = 1'b0;
  bit            m_done = 1'b0;
  bit            slv_busy = 1'b0;
  int            slv_idx = 0;
  int            slv_len = 0;
  logic [AW-1:0] slv_addr = '0;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return 16'(a * 28'd40503) ^ 16'(a >> 5) ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ar(input string name, input int idx, input logic [AW-1:0] a, input logic [7:0] l);
    if (idx < ar_addr_log.size()) begin
      chk({name, "_addr"}, 64'(ar_addr_log[idx]), 64'(a));
      chk({name, "_len"}, 64'(ar_len_log[idx]), 64'(l));
    end else begin
      chk({name, "_count"}, 64'(ar_addr_log.size()), 64'(idx + 1));
    end
  endtask

  // AXI slave + FIFO readiness driver; presents the next beat of the outstanding burst.
  initial begin
    bus_if.arready = 1'b0;
    bus_if.rvalid = 1'b0;
    bus_if.rdata = '0;
    bus_if.rlast = 1'b0;
    bus_if.rresp = 2'b00;
    bus_if.fifo_wr_vld = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.arready = (ar_mode == 2) ? 1'b0 : (ar_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      bus_if.fifo_wr_vld = (wv_mode == 2) ? 1'b0 : (wv_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      bus_if.rvalid = (rv_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (slv_busy) begin
        bus_if.rdata = mem(slv_addr + AW'(slv_idx * (DW / 8)));
        bus_if.rlast = (slv_idx == slv_len);
      end else begin
        bus_if.rdata = 16'($urandom);
        bus_if.rlast = 1'($urandom_range(0, 1));
      end
      bus_if.rresp = (err_mode != 0 && $urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
    end
  end

  // Reference model and per-cycle compare; inputs are stable here until the next edge.
  initial begin
    bit was_idle, exp_arv, exp_rr, exp_wr, new_done;
    int rem;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_fifo_wr_en", 64'(bus_if.fifo_wr_en), 64'(0));
        exp_ar_addr.delete();
        exp_ar_len.delete();
        exp_data.delete();
        m_active = 1'b0;
        m_done = 1'b0;
        slv_busy = 1'b0;
        slv_idx = 0;
        slv_len = 0;
`ifdef RDATA3_FETCH_ERR_EN
        m_err = 1'b0;
`endif
      end else begin
        was_idle = !m_active && !m_done;
        exp_arv = m_active && !slv_busy;
        exp_rr = slv_busy && bus_if.fifo_wr_vld;
        exp_wr = exp_rr && bus_if.rvalid;
        chk("busy", 64'(busy), 64'(m_active));
        chk("frame_done", 64'(frame_done), 64'(m_done));
        chk("arvalid", 64'(bus_if.arvalid), 64'(exp_arv));
        chk("rready", 64'(bus_if.rready), 64'(exp_rr));
        chk("fifo_wr_en", 64'(bus_if.fifo_wr_en), 64'(exp_wr));
`ifdef RDATA3_FETCH_ERR_EN
        chk("rd_err", 64'(rd_err), 64'(m_err));
`endif
        if (exp_arv && exp_ar_addr.size() != 0) begin
          chk("araddr", 64'(bus_if.araddr), 64'(exp_ar_addr[0]));
          chk("arlen", 64'(bus_if.arlen), 64'(exp_ar_len[0]));
        end
        if (exp_wr && exp_data.size() != 0) begin
          chk("fifo_wr_data", 64'(bus_if.fifo_wr_data), 64'(exp_data[0]));
        end
        if (frame_done) done_count++;
        if (bus_if.fifo_wr_en) dut_wr_count++;

        new_done = 1'b0;
        if (exp_arv && bus_if.arready && exp_ar_addr.size() != 0) begin
          ar_addr_log.push_back(bus_if.araddr);
          ar_len_log.push_back(bus_if.arlen);
          slv_addr = exp_ar_addr.pop_front();
          slv_len = int'(exp_ar_len.pop_front());
          slv_idx = 0;
          slv_busy = 1'b1;
        end
        if (exp_wr) begin
          if (exp_data.size() != 0) void'(exp_data.pop_front());
`ifdef RDATA3_FETCH_ERR_EN
          if (bus_if.rresp != 2'b00) m_err = 1'b1;
`endif
          if (slv_idx == slv_len) slv_busy = 1'b0;
          slv_idx++;
          if (exp_data.size() == 0) begin
            m_active = 1'b0;
            slv_busy = 1'b0;
            new_done = 1'b1;
          end
        end
        if (was_idle && frame_start) begin
`ifdef RDATA3_FETCH_ERR_EN
          m_err = 1'b0;
`endif
          if (frame_beats == 24'd0) begin
            new_done = 1'b1;
          end else begin
            m_active = 1'b1;
            for (int k = 0; k * BL < int'(frame_beats); k++) begin
              rem = int'(frame_beats) - k * BL;
              exp_ar_addr.push_back(base_addr + AW'(k * BB));
              exp_ar_len.push_back(8'(((rem > BL) ? BL : rem) - 1));
            end
            for (int i = 0; i < int'(frame_beats); i++) begin
              exp_data.push_back(mem(base_addr + AW'(i * (DW / 8))));
            end
          end
        end
        m_done = new_done;
      end
    end
  end

  task automatic start_frame(input logic [AW-1:0] b, input logic [23:0] n);
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    base_addr = b;
    frame_beats = n;
    $display("frame start base=%07h beats=%0d t=%0t", b, n, $time);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0;
    int i;
    d0 = done_count;
    i = 0;
    while (done_count == d0 && i < limit) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk(name, 64'(done_count != d0), 64'(1));
  endtask

  task automatic wait_ar(input string name, input int target, input int limit);
    int i;
    i = 0;
    while (ar_addr_log.size() < target && i < limit) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk(name, 64'(ar_addr_log.size() >= target), 64'(1));
  endtask

  task automatic wait_wr(input string name, input int target, input int limit);
    int i;
    i = 0;
    while (dut_wr_count < target && i < limit) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk(name, 64'(dut_wr_count >= target), 64'(1));
  endtask

  initial begin
    int n0, w0, d0;
    logic [AW-1:0] rb;
    logic [23:0] rn;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_arvalid", 64'(bus_if.arvalid), 64'(0));
    chk("rst_rready", 64'(bus_if.rready), 64'(0));
    chk("rst_araddr", 64'(bus_if.araddr), 64'(0));
    chk("rst_arlen", 64'(bus_if.arlen), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 40-beat frame at 0x1000 with an always-ready fabric
    n0 = ar_addr_log.size();
    w0 = dut_wr_count;
    d0 = done_count;
    start_frame(28'h0001000, 24'd40);
    wait_done("f40_done", 400);
    chk_ar("f40_ar0", n0, 28'h0001000, 8'd15);
    chk_ar("f40_ar1", n0 + 1, 28'h0001020, 8'd15);
    chk_ar("f40_ar2", n0 + 2, 28'h0001040, 8'd7);
    chk("f40_ar_count", 64'(ar_addr_log.size() - n0), 64'(3));
    chk("f40_writes", 64'(dut_wr_count - w0), 64'(40));
    chk("f40_done_count", 64'(done_count - d0), 64'(1));
`ifdef RDATA3_FETCH_ERR_EN
    chk("f40_no_err", 64'(rd_err), 64'(0));
`endif

    // zero-beat frame: done pulse next cycle, no AR
    n0 = ar_addr_log.size();
    start_frame(28'h0002000, 24'd0);
    @(negedge clk);
    #1;
    chk("zero_done_pulse", 64'(frame_done), 64'(1));
    chk("zero_not_busy", 64'(busy), 64'(0));
    @(negedge clk);
    #1;
    chk("zero_done_once", 64'(frame_done), 64'(0));
    chk("zero_no_ar", 64'(ar_addr_log.size()), 64'(n0));

    // FIFO not ready for 5 cycles mid-burst
    w0 = dut_wr_count;
    start_frame(28'h0004000, 24'd32);
    wait_wr("stall_reach", w0 + 5, 100);
    wv_mode = 2;
    n0 = dut_wr_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_rready", 64'(bus_if.rready), 64'(0));
    end
    chk("stall_no_writes", 64'(dut_wr_count), 64'(n0));
    wv_mode = 1;
    wait_done("stall_done", 200);
    chk("stall_writes", 64'(dut_wr_count - w0), 64'(32));

    // arready held low for 10 cycles
    ar_mode = 2;
    n0 = ar_addr_log.size();
    start_frame(28'h0006000, 24'd20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("arhold_valid", 64'(bus_if.arvalid), 64'(1));
      chk("arhold_addr", 64'(bus_if.araddr), 64'(28'h0006000));
      chk("arhold_len", 64'(bus_if.arlen), 64'(15));
    end
    chk("arhold_no_ar", 64'(ar_addr_log.size()), 64'(n0));
    ar_mode = 1;
    wait_done("arhold_done", 200);
    chk_ar("arhold_ar0", n0, 28'h0006000, 8'd15);
    chk_ar("arhold_ar1", n0 + 1, 28'h0006020, 8'd3);

    // frame_start while busy is ignored
    ar_mode = 0; rv_mode = 0; wv_mode = 0;
    n0 = ar_addr_log.size();
    w0 = dut_wr_count;
    d0 = done_count;
    start_frame(28'h0007000, 24'd50);
    repeat (10) @(posedge clk);
    start_frame(28'h0009000, 24'd7);
    wait_done("ign_done", 2000);
    repeat (5) @(negedge clk);
    #1;
    chk("ign_done_count", 64'(done_count - d0), 64'(1));
    chk("ign_writes", 64'(dut_wr_count - w0), 64'(50));
    chk("ign_ar_count", 64'(ar_addr_log.size() - n0), 64'(4));
    chk_ar("ign_ar3", n0 + 3, 28'h0007060, 8'd1);

    // address wraps at 2^28
    ar_mode = 1; rv_mode = 1; wv_mode = 1;
    n0 = ar_addr_log.size();
    start_frame(28'hFFFFFE0, 24'd48);
    wait_done("wrap_done", 400);
    chk_ar("wrap_ar0", n0, 28'hFFFFFE0, 8'd15);
    chk_ar("wrap_ar1", n0 + 1, 28'h0000000, 8'd15);
    chk_ar("wrap_ar2", n0 + 2, 28'h0000020, 8'd15);

    // reset during the second burst, then a fresh frame
    n0 = ar_addr_log.size();
    start_frame(28'h0003000, 24'd64);
    wait_ar("rst_second_burst", n0 + 2, 200);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_rready", 64'(bus_if.rready), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_frame_done", 64'(frame_done), 64'(0));
    chk("midrst_arvalid", 64'(bus_if.arvalid), 64'(0));
    chk("midrst_rready", 64'(bus_if.rready), 64'(0));
    chk("midrst_fifo_wr_en", 64'(bus_if.fifo_wr_en), 64'(0));
    chk("midrst_araddr", 64'(bus_if.araddr), 64'(0));
    chk("midrst_arlen", 64'(bus_if.arlen), 64'(0));
`ifdef RDATA3_FETCH_ERR_EN
    chk("midrst_rd_err", 64'(rd_err), 64'(0));
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ar_mode = 0; rv_mode = 0; wv_mode = 0; err_mode = 1;
    n0 = ar_addr_log.size();
    w0 = dut_wr_count;
    start_frame(28'h0005000, 24'd20);
    wait_done("post_rst_done", 1000);
    chk_ar("post_rst_ar0", n0, 28'h0005000, 8'd15);
    chk_ar("post_rst_ar1", n0 + 1, 28'h0005020, 8'd3);
    chk("post_rst_writes", 64'(dut_wr_count - w0), 64'(20));

    // randomized frames, back to back
    for (int f = 0; f < 12; f++) begin
      ar_mode = $urandom_range(0, 1);
      rv_mode = $urandom_range(0, 1);
      wv_mode = $urandom_range(0, 1);
      rb = AW'($urandom) & ~AW'(BB - 1);
      rn = 24'($urandom_range(0, 70));
      w0 = dut_wr_count;
      start_frame(rb, rn);
      wait_done("rand_done", 2000);
      chk("rand_writes", 64'(dut_wr_count - w0), 64'(rn));
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
